// File: rtl/mul_2bit_seq_pkg.sv
// Shared types and helpers for the digit-serial multiplier controller.
// Imported by mul_2bit_seq and its bench.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_e;

    localparam int unsigned TILE_W = 2;

    // Counter width for n values; never narrower than one bit.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_2bit_seq_tile.sv
// 2x2 unsigned multiplier tile, purely combinational.
// Shared by the sequential controller, one digit pair per cycle.
module mul_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] out
);

    assign out = {2'b00, a} * {2'b00, b};

endmodule

// File: rtl/mul_2bit_seq.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around one mul_2bit tile.
// Digit pairs are issued i-outer / j-inner and shift-added into an accumulator.
module mul_2bit_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned DIG = WIDTH / 2;
    localparam int unsigned NPP = DIG * DIG;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned CW  = clog2_safe(DIG);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("mul_2bit_seq: WIDTH must be even and >= 2");
    end

    mul_state_e           state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [PW-1:0]        acc;
    logic [CW-1:0]        i;
    logic [CW-1:0]        j;

    logic [TILE_W-1:0]    a_dig;
    logic [TILE_W-1:0]    b_dig;
    logic [3:0]           pp;
    logic [PW-1:0]        pp_ext;
    logic [PW-1:0]        sum;
    int unsigned          sh;
    logic                 last_j;
    logic                 last_pair;

    mul_2bit u_tile (
        .a   (a_dig),
        .b   (b_dig),
        .out (pp)
    );

    // Digit select as an explicit mux keeps the part-select in range for every WIDTH.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int unsigned k = 0; k < DIG; k++) begin
            if (32'(i) == k) a_dig = a_q[k*TILE_W +: TILE_W];
            if (32'(j) == k) b_dig = b_q[k*TILE_W +: TILE_W];
        end
    end

    always_comb begin
        sh        = TILE_W * (32'(i) + 32'(j));
        pp_ext    = PW'(pp);
        sum       = acc + (pp_ext << sh);
        last_j    = (32'(j) == DIG - 1);
        last_pair = ((32'(i) * DIG + 32'(j)) == NPP - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum;
                    if (last_j) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                    if (last_pair) begin
                        product   <= sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_2bit_seq.sv
// Scoreboard bench for mul_2bit_seq at WIDTH=8 and WIDTH=2.
// Expected products are queued on issue and compared when out_valid rises.
module tb_mul_2bit_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv8 = 1'b0, or8 = 1'b1;
    logic        rdy8, ov8, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    logic        iv2 = 1'b0, or2 = 1'b1;
    logic        rdy2, ov2, busy2;
    logic [1:0]  a2 = '0, b2 = '0;
    logic [3:0]  p2;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] q8[$];
    logic [3:0]  q2[$];

    mul_2bit_seq #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (rdy8),
        .a         (a8),
        .b         (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .product   (p8),
        .busy      (busy8)
    );

    mul_2bit_seq #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv2),
        .in_ready  (rdy2),
        .a         (a2),
        .b         (b2),
        .out_valid (ov2),
        .out_ready (or2),
        .product   (p2),
        .busy      (busy2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        a8  = a;
        b8  = b;
        iv8 = 1'b1;
        q8.push_back(16'(a) * 16'(b));
        while (!rdy8 && n < 50) begin
            tick();
            n++;
        end
        check_eq("accept8", 32'(rdy8), 1);
        tick();
        iv8 = 1'b0;
        check_eq("in_ready_drop8", 32'(rdy8), 0);
        check_eq("busy_run8", 32'(busy8), 1);
    endtask

    task automatic recv8(input int stall, input bit scramble, input bit pend,
                         input logic [7:0] pa, input logic [7:0] pb);
        int n = 0;
        logic [15:0] exp;
        or8 = (stall == 0);
        while (!ov8 && n < 100) begin
            if (scramble) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            tick();
            n++;
        end
        check_eq("latency8", 32'(n), 16);
        exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        check_eq("product8", 32'(p8), 32'(exp));
        for (int k = 0; k < stall; k++) begin
            if (pend) begin
                a8  = pa;
                b8  = pb;
                iv8 = 1'b1;
            end
            tick();
            check_eq("hold_valid8", 32'(ov8), 1);
            check_eq("hold_product8", 32'(p8), 32'(exp));
            check_eq("no_accept8", 32'(rdy8), 0);
        end
        or8 = 1'b1;
        tick();
        check_eq("handshake_valid8", 32'(ov8), 0);
        check_eq("idle_ready8", 32'(rdy8), 1);
        check_eq("idle_busy8", 32'(busy8), 0);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b);
        int n = 0;
        logic [3:0] exp;
        a2  = a;
        b2  = b;
        iv2 = 1'b1;
        q2.push_back({2'b00, a} * {2'b00, b});
        while (!rdy2 && n < 20) begin
            tick();
            n++;
        end
        check_eq("accept2", 32'(rdy2), 1);
        tick();
        iv2 = 1'b0;
        n = 0;
        while (!ov2 && n < 20) begin
            tick();
            n++;
        end
        check_eq("latency2", 32'(n), 1);
        exp = (q2.size() > 0) ? q2.pop_front() : 4'hx;
        check_eq("product2", 32'(p2), 32'(exp));
        tick();
        check_eq("handshake_valid2", 32'(ov2), 0);
    endtask

    initial begin
        repeat (2) tick();
        check_eq("rst_in_ready", 32'(rdy8), 1);
        check_eq("rst_out_valid", 32'(ov8), 0);
        check_eq("rst_busy", 32'(busy8), 0);
        check_eq("rst_product", 32'(p8), 0);
        check_eq("rst_out_valid2", 32'(ov2), 0);
        rst_n = 1'b1;
        tick();

        send8(8'hB7, 8'h5C);
        recv8(0, 1'b0, 1'b0, 8'h00, 8'h00);

        send8(8'hFF, 8'hFF);
        recv8(0, 1'b0, 1'b0, 8'h00, 8'h00);
        send8(8'h00, 8'hA5);
        recv8(0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Backpressure with a new operand pair waiting on in_valid.
        send8(8'h12, 8'h34);
        recv8(5, 1'b0, 1'b1, 8'h21, 8'h07);
        send8(8'h21, 8'h07);
        recv8(0, 1'b0, 1'b0, 8'h00, 8'h00);

        send8(8'h0F, 8'h03);
        recv8(0, 1'b1, 1'b0, 8'h00, 8'h00);

        // Abort mid-run: the in-flight result must never appear.
        send8(8'hAA, 8'h55);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", 32'(ov8), 0);
        check_eq("abort_product", 32'(p8), 0);
        check_eq("abort_in_ready", 32'(rdy8), 1);
        check_eq("abort_busy", 32'(busy8), 0);
        if (q8.size() > 0) void'(q8.pop_back());
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send8(8'h03, 8'h05);
        recv8(0, 1'b0, 1'b0, 8'h00, 8'h00);

        run2(2'd3, 2'd3);
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                run2(2'(x), 2'(y));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
